// File: rtl/sum_accum.sv
// sum_accum: batch accumulator for 5-bit adder results {in_cout,in_sum}.
// Accepts BATCH results, then presents the 8-bit (mod 256) total, the
// count and a sticky overflow flag until the consumer takes them.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   in_valid   - adder result on in_sum/in_cout is valid
//   in_sum     - 4-bit adder sum
//   in_cout    - adder carry-out
//   in_ready   - block can accept a result this cycle (ACCUM state)
//   clr        - synchronous clear, highest priority
//   out_valid  - batch result presented (DONE state)
//   out_ready  - consumer takes the batch result
//   out_total  - running / batch sum, mod 256
//   out_count  - results accepted in the current batch
//   out_ovf    - sticky: total wrapped during this batch
module sum_accum #(
  parameter int BATCH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [3:0] in_sum,
  input  logic       in_cout,
  output logic       in_ready,
  input  logic       clr,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_total,
  output logic [3:0] out_count,
  output logic       out_ovf
);

  localparam logic [3:0] BATCH_L = 4'(BATCH);

  typedef enum logic {
    ACCUM,
    DONE
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  total, total_nx;
  logic [3:0]  count, count_nx;
  logic        ovf, ovf_nx;
  logic [8:0]  sum9;
  logic [3:0]  count_inc;

  assign sum9      = {1'b0, total} + {4'b0000, in_cout, in_sum};
  assign count_inc = count + 4'd1;

  always_comb begin
    state_nx = state;
    total_nx = total;
    count_nx = count;
    ovf_nx   = ovf;
    if (clr) begin
      // clr beats both the input beat and the output handshake
      state_nx = ACCUM;
      total_nx = '0;
      count_nx = '0;
      ovf_nx   = 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            total_nx = sum9[7:0];
            count_nx = count_inc;
            ovf_nx   = ovf | sum9[8];
            if (count_inc == BATCH_L) state_nx = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_nx = ACCUM;
            total_nx = '0;
            count_nx = '0;
            ovf_nx   = 1'b0;
          end
        end
        default: state_nx = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ACCUM;
      total <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      total <= total_nx;
      count <= count_nx;
      ovf   <= ovf_nx;
    end
  end

  // Handshake outputs depend on state only: no input-to-output paths.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign out_total = total;
  assign out_count = count;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_sum_accum.sv
// Scoreboard bench for sum_accum: stimulus pushes expected batch results,
// per-instance monitors pop and compare on each output handshake.
module tb_sum_accum;

  typedef struct packed {
    logic [7:0] t;
    logic [3:0] c;
    logic       o;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // BATCH=4 instance
  logic       in_valid4, in_cout4, in_ready4, clr4, out_valid4, out_ready4, out_ovf4;
  logic [3:0] in_sum4, out_count4;
  logic [7:0] out_total4;
  // BATCH=9 instance
  logic       in_valid9, in_cout9, in_ready9, clr9, out_valid9, out_ready9, out_ovf9;
  logic [3:0] in_sum9, out_count9;
  logic [7:0] out_total9;

  int checks = 0;
  int errors = 0;
  exp_t q4[$];
  exp_t q9[$];

  sum_accum #(.BATCH(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_sum(in_sum4),
    .in_cout(in_cout4), .in_ready(in_ready4), .clr(clr4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_total(out_total4), .out_count(out_count4),
    .out_ovf(out_ovf4)
  );

  sum_accum #(.BATCH(9)) dut9 (
    .clk(clk), .reset(reset), .in_valid(in_valid9), .in_sum(in_sum9),
    .in_cout(in_cout9), .in_ready(in_ready9), .clr(clr9), .out_valid(out_valid9),
    .out_ready(out_ready9), .out_total(out_total9), .out_count(out_count9),
    .out_ovf(out_ovf9)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one beat on the BATCH=4 instance for exactly one cycle.
  task automatic beat4(input logic [4:0] v);
    in_valid4 = 1'b1;
    {in_cout4, in_sum4} = v;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
  endtask

  task automatic idle4();
    @(posedge clk); #1;
  endtask

  task automatic pulse_clr4();
    clr4 = 1'b1;
    @(posedge clk); #1;
    clr4 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset && !clr4 && out_valid4 && out_ready4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL batch4_unexpected: got total=0x%0h count=%0d, required no batch", out_total4, out_count4);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("batch4_result", {19'd0, out_total4, out_count4, out_ovf4}, {19'd0, e});
      end
    end
  end

  always @(negedge clk) begin
    if (reset && !clr9 && out_valid9 && out_ready9) begin
      if (q9.size() == 0) begin
        checks++; errors++;
        $display("FAIL batch9_unexpected: got total=0x%0h count=%0d, required no batch", out_total9, out_count9);
      end else begin
        exp_t e;
        e = q9.pop_front();
        chk("batch9_result", {19'd0, out_total9, out_count9, out_ovf9}, {19'd0, e});
      end
    end
  end

  initial begin
    reset = 1'b0;
    in_valid4 = 0; in_sum4 = 0; in_cout4 = 0; clr4 = 0; out_ready4 = 0;
    in_valid9 = 0; in_sum9 = 0; in_cout9 = 0; clr9 = 0; out_ready9 = 1;

    // Reset state
    #1;
    chk("rst_total", out_total4, 0);
    chk("rst_count", out_count4, 0);
    chk("rst_ovf", out_ovf4, 0);
    chk("rst_ready_valid", {in_ready4, out_valid4}, 2'b10);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Normal batch: 2+23+15+30 = 70 = 0x46
    out_ready4 = 1'b1;
    q4.push_back('{t: 8'h46, c: 4'd4, o: 1'b0});
    beat4(5'd2); beat4(5'd23); beat4(5'd15);
    chk("norm_partial_total", out_total4, 40);
    beat4(5'd30);
    chk("norm_done_valid", {in_ready4, out_valid4}, 2'b01);
    idle4();
    chk("norm_after_hs", {in_ready4, out_valid4, out_total4, out_count4, out_ovf4}, {2'b10, 8'd0, 4'd0, 1'b0});

    // Backpressure: batch 1+2+3+4 = 10, value 5 held while stalled
    out_ready4 = 1'b0;
    beat4(5'd1); beat4(5'd2); beat4(5'd3); beat4(5'd4);
    in_valid4 = 1'b1; {in_cout4, in_sum4} = 5'd5;
    for (int i = 0; i < 3; i++) begin
      idle4();
      chk("bp_stall", {out_valid4, in_ready4, out_total4, out_count4}, {2'b10, 8'd10, 4'd4});
    end
    q4.push_back('{t: 8'd10, c: 4'd4, o: 1'b0});
    out_ready4 = 1'b1;
    idle4();
    out_ready4 = 1'b0;
    chk("bp_after_hs", {in_ready4, out_total4, out_count4}, {1'b1, 8'd0, 4'd0});
    idle4();
    in_valid4 = 1'b0;
    chk("bp_held_accepted", {out_total4, out_count4}, {8'd5, 4'd1});
    pulse_clr4();

    // Clear drops the coincident beat
    beat4(5'd10); beat4(5'd10);
    chk("clr_pre", {out_total4, out_count4}, {8'd20, 4'd2});
    clr4 = 1'b1; in_valid4 = 1'b1; {in_cout4, in_sum4} = 5'd7;
    idle4();
    clr4 = 1'b0; in_valid4 = 1'b0;
    chk("clr_cleared", {out_total4, out_count4, out_ovf4}, {8'd0, 4'd0, 1'b0});
    idle4();
    chk("clr_dropped", {out_total4, out_count4}, {8'd0, 4'd0});

    // Reset mid-batch, asserted between edges
    beat4(5'd31); beat4(5'd31); beat4(5'd31);
    chk("rstmid_pre", {out_total4, out_count4}, {8'd93, 4'd3});
    #2 reset = 1'b0;
    #1;
    chk("rstmid_async", {in_ready4, out_valid4, out_total4, out_count4, out_ovf4}, {2'b10, 8'd0, 4'd0, 1'b0});
    for (int i = 0; i < 2; i++) begin
      idle4();
      chk("rstmid_hold", {out_valid4, out_count4}, {1'b0, 4'd0});
    end
    @(negedge clk);
    reset = 1'b1;
    in_valid4 = 1'b1; {in_cout4, in_sum4} = 5'd1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    chk("rst_first_edge_accept", {out_total4, out_count4}, {8'd1, 4'd1});
    pulse_clr4();

    // Bubbles: 1, gap, 1, gap, 1, 1
    out_ready4 = 1'b1;
    q4.push_back('{t: 8'd4, c: 4'd4, o: 1'b0});
    beat4(5'd1); idle4();
    chk("bub_gap1", out_count4, 1);
    beat4(5'd1); idle4();
    chk("bub_gap2", out_count4, 2);
    beat4(5'd1);
    beat4(5'd1);
    chk("bub_done", {out_valid4, out_total4, out_count4}, {1'b1, 8'd4, 4'd4});
    idle4();
    out_ready4 = 1'b0;

    // Overflow on BATCH=9: 9*31 = 279 -> 0x17, ovf set
    q9.push_back('{t: 8'h17, c: 4'd9, o: 1'b1});
    for (int i = 0; i < 9; i++) begin
      in_valid9 = 1'b1; {in_cout9, in_sum9} = 5'd31;
      @(posedge clk); #1;
      if (i == 7) chk("ovf_before_wrap", {out_total9, out_count9, out_ovf9}, {8'd248, 4'd8, 1'b0});
    end
    in_valid9 = 1'b0;
    chk("ovf_done", {out_valid9, out_ovf9}, 2'b11);
    idle4();
    chk("ovf_cleared", {out_valid9, out_total9, out_count9, out_ovf9}, {1'b0, 8'd0, 4'd0, 1'b0});

    // Every pushed expectation must have been consumed, within a bound
    for (int i = 0; i < 10; i++) begin
      if (q4.size() == 0 && q9.size() == 0) break;
      idle4();
    end
    chk("scoreboard_drained", q4.size() + q9.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_accum.md
SUM_ACCUM -- requirements
Module: sum_accum

Interface
REQ-001 The block SHALL have parameter BATCH, default 4, meaning the number of adder results per batch; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1; one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1, meaning the adder result on in_sum/in_cout is valid.
REQ-005 The block SHALL have port in_sum, input, 4, meaning the 4-bit adder sum.
REQ-006 The block SHALL have port in_cout, input, 1, meaning the adder carry-out.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the block can accept a result this cycle.
REQ-008 The block SHALL have port clr, input, 1, a synchronous clear.
REQ-009 The block SHALL have port out_valid, output, 1, meaning a batch result is presented.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer takes the batch result.
REQ-011 The block SHALL have port out_total, output, 8, meaning the running or batch sum.
REQ-012 The block SHALL have port out_count, output, 4, meaning the results accepted in the current batch.
REQ-013 The block SHALL have port out_ovf, output, 1, a sticky flag meaning the 8-bit total wrapped during this batch.

Function
REQ-014 The block SHALL implement two states:
- ACCUM: in_ready=1, out_valid=0.
- DONE: in_ready=0, out_valid=1.
- in_ready and out_valid SHALL be decoded from state only.
REQ-015 The block SHALL accept a beat when in_valid=1 and in_ready=1 (ACCUM state) and clr=0.
REQ-016 On each accepted beat:
- The operand SHALL be the 5-bit value {in_cout,in_sum} (0..31), zero-extended to 9 bits.
- out_total SHALL be updated to (out_total + operand) mod 256.
- out_count SHALL increment by 1.
- out_ovf SHALL be set if the 9-bit sum is >= 256; once set, out_ovf SHALL stay set until cleared.
REQ-017 The accumulation latency SHALL be one cycle: out_total, out_count and out_ovf SHALL reflect an accepted beat on the cycle after the accepting edge.
REQ-018 When an accepted beat makes out_count equal BATCH, the block SHALL enter DONE on that same edge.
REQ-019 In DONE, out_total, out_count and out_ovf SHALL hold stable; in_valid SHALL be ignored and no beat SHALL be accepted.
REQ-020 On out_valid=1 and out_ready=1, the block SHALL clear out_total, out_count and out_ovf to 0 and return to ACCUM on the next edge.
- The first new beat SHALL be acceptable on the cycle after the handshake.
REQ-021 out_ready SHALL be ignored while the block is in ACCUM.
REQ-022 When clr=1, the block SHALL clear out_total, out_count and out_ovf and force ACCUM on the next edge, regardless of state.
- clr SHALL have priority over the input beat and the output handshake.
- A beat presented with clr=1 SHALL be dropped.
- clr=1 SHALL NOT complete the output handshake.
REQ-023 If in_valid=0 in ACCUM, the block SHALL leave all state unchanged.
REQ-024 The block SHALL NOT hold any combinational path from inputs to outputs.

Reset
REQ-025 While reset=0, the block SHALL asynchronously force state=ACCUM, out_total=0, out_count=0 and out_ovf=0; therefore in_ready=1 and out_valid=0.
REQ-026 Asserting reset mid-batch or in DONE SHALL discard the partial or pending result, with no output handshake.
REQ-027 The block SHALL be able to accept a beat on the first rising edge after reset returns to 1.

Verification
REQ-028 The bench SHALL cover normal batch completion:
- Stimulus: BATCH=4; beats {cout,sum} = 2, 23, 15, 30 on consecutive cycles; out_ready=1.
- Response: out_valid=1 for 1 cycle with out_total=8'h46, out_count=4, out_ovf=0; then ACCUM with all outputs 0.
REQ-029 The bench SHALL cover overflow:
- Stimulus: BATCH=9; nine beats of 31.
- Response: out_total=8'h17 (279 mod 256), out_count=9, out_ovf=1.
REQ-030 The bench SHALL cover backpressure:
- Stimulus: BATCH=4 batch completes; out_ready=0 for 3 cycles with in_valid=1 and value 5 held.
- Response: out_valid, out_total and out_count stable; no beat accepted; the handshake occurs on the 4th cycle; the value 5 is accepted on the following cycle.
REQ-031 The bench SHALL cover clear:
- Stimulus: 2 beats of 10; then clr=1 together with in_valid=1 and value 7.
- Response: the next cycle shows out_total=0, out_count=0; the 7 is dropped.
REQ-032 The bench SHALL cover reset mid-batch:
- Stimulus: 3 beats of 31; reset=0 asserted between clock edges.
- Response: outputs are 0 immediately, before the next edge; out_valid is never raised.
REQ-033 The bench SHALL cover bubbles:
- Stimulus: beats 1, gap, 1, gap, 1, 1 with BATCH=4.
- Response: out_total=4, out_count=4; gaps do not advance the count.
